// File: rtl/gray_counter.sv
// Registered binary/Gray up-down counter with wrap pulse and synchronous load,
// plus a synchronised Gray-to-binary decode path for a pointer from another clock domain.
module gray_counter #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  input  logic [WIDTH-1:0] remote_gray_in,
  output logic [WIDTH-1:0] remote_bin_out,
  output logic             remote_valid
);

  localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]       VALID_LIMIT = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] remote_bin_q, remote_bin_d;
  logic [2:0]       vcnt_q, vcnt_d;

  // Load beats enable; the Gray code is computed from the next binary value so
  // both registers update together and gray_out never passes through a decoder.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ALL_ONES);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == '0);
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    remote_bin_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      remote_bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  always_comb begin
    vcnt_d = vcnt_q;
    if (vcnt_q != VALID_LIMIT) vcnt_d = vcnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      remote_bin_q <= '0;
      vcnt_q       <= '0;
    end else begin
      sync_q[0] <= remote_gray_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      remote_bin_q <= remote_bin_d;
      vcnt_q       <= vcnt_d;
    end
  end

  // remote_valid is a level with no ready: once high, remote_bin_out carries a
  // meaningful decoded pointer every cycle until the next reset.
  assign remote_valid   = (vcnt_q == VALID_LIMIT);
  assign remote_bin_out = remote_bin_q;
  assign bin_out        = bin_q;
  assign gray_out       = gray_q;
  assign wrap           = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: WIDTH=4 instance for directed count/remote vectors,
// WIDTH=8 instance for a long randomised run against a reference model.
module tb_gray_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en4, up4, load4;
  logic [3:0] lb4, bin4, gray4, rgray4, rbin4;
  logic       wrap4, rvalid4;

  logic       en8, up8, load8;
  logic [7:0] lb8, bin8, gray8, rgray8, rbin8;
  logic       wrap8, rvalid8;

  gray_counter #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .load(load4), .load_bin(lb4),
    .bin_out(bin4), .gray_out(gray4), .wrap(wrap4),
    .remote_gray_in(rgray4), .remote_bin_out(rbin4), .remote_valid(rvalid4)
  );

  gray_counter #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .up(up8), .load(load8), .load_bin(lb8),
    .bin_out(bin8), .gray_out(gray8), .wrap(wrap8),
    .remote_gray_in(rgray8), .remote_bin_out(rbin8), .remote_valid(rvalid8)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] exp4_q[$];  // {wrap, gray, bin}
  logic [8:0] exp8_q[$];  // {wrap, bin}

  logic [3:0] gray_tab [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of count inputs and queues the expected post-edge outputs.
  task automatic step4(input logic e, input logic u, input logic l, input logic [3:0] lb,
                       input logic [3:0] eb, input logic [3:0] eg, input logic ew);
    @(negedge clk);
    en4 = e; up4 = u; load4 = l; lb4 = lb;
    exp4_q.push_back({ew, eg, eb});
  endtask

  task automatic idle4();
    @(negedge clk);
    en4 = 1'b0; load4 = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp4_q.size() > 0) begin
      logic [8:0] e;
      e = exp4_q.pop_front();
      check("bin4",  32'(bin4),  32'(e[3:0]));
      check("gray4", 32'(gray4), 32'(e[7:4]));
      check("wrap4", 32'(wrap4), 32'(e[8]));
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp8_q.size() > 0) begin
      logic [8:0] e;
      logic [7:0] b;
      e = exp8_q.pop_front();
      b = e[7:0];
      check("bin8",  32'(bin8),  32'(b));
      check("gray8", 32'(gray8), 32'(b ^ (b >> 1)));
      check("wrap8", 32'(wrap8), 32'(e[8]));
    end
  end

  initial begin
    logic [7:0] m;
    logic       w;
    rst_n = 1'b0;
    en4 = 0; up4 = 0; load4 = 0; lb4 = '0; rgray4 = 4'b1101;
    en8 = 0; up8 = 0; load8 = 0; lb8 = '0; rgray8 = '0;

    #7;
    check("rst_bin",    32'(bin4),    0);
    check("rst_gray",   32'(gray4),   0);
    check("rst_wrap",   32'(wrap4),   0);
    check("rst_rbin",   32'(rbin4),   0);
    check("rst_rvalid", 32'(rvalid4), 0);

    // Remote path: input held at 1101 across release.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    check("rvalid_e1", 32'(rvalid4), 0);
    check("rbin_e1",   32'(rbin4),   0);
    @(posedge clk); #2;
    check("rvalid_e2", 32'(rvalid4), 0);
    check("rbin_e2",   32'(rbin4),   0);
    @(posedge clk); #2;
    check("rvalid_e3", 32'(rvalid4), 1);
    check("rbin_e3",   32'(rbin4),   32'(4'b1001));
    @(negedge clk); rgray4 = 4'b1000;
    @(posedge clk); #2; check("rbin_s1", 32'(rbin4), 32'(4'b1001));
    @(posedge clk); #2; check("rbin_s2", 32'(rbin4), 32'(4'b1001));
    @(posedge clk); #2; check("rbin_s3", 32'(rbin4), 32'(4'b1111));

    // Full up-count lap.
    check("start_bin", 32'(bin4), 0);
    for (int k = 1; k <= 16; k++)
      step4(1, 1, 0, 4'h0, 4'(k), gray_tab[k], k == 16);

    // Down-wrap, direction change with no bubble, load priority at wrap boundary.
    step4(1, 0, 0, 4'h0, 4'hF, 4'b1000, 1);
    step4(1, 0, 0, 4'h0, 4'hE, 4'b1001, 0);
    step4(1, 1, 0, 4'h0, 4'hF, 4'b1000, 0);
    step4(1, 1, 1, 4'h9, 4'h9, 4'b1101, 0);
    step4(0, 1, 0, 4'h0, 4'h9, 4'b1101, 0);
    step4(1, 1, 0, 4'h0, 4'hA, 4'b1111, 0);
    step4(0, 0, 1, 4'h5, 4'h5, 4'b0111, 0);

    // Reset mid-cycle with count = 5 and en = 1.
    @(posedge clk); #3;
    en4 = 1'b1; up4 = 1'b1; load4 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_bin",    32'(bin4),    0);
    check("mid_gray",   32'(gray4),   0);
    check("mid_wrap",   32'(wrap4),   0);
    check("mid_rbin",   32'(rbin4),   0);
    check("mid_rvalid", 32'(rvalid4), 0);
    @(negedge clk); rst_n = 1'b1;
    exp4_q.push_back({1'b0, 4'b0001, 4'b0001});
    fork
      begin
        @(posedge clk); #2; check("rerel_v1", 32'(rvalid4), 0);
        @(posedge clk); #2; check("rerel_v2", 32'(rvalid4), 0);
        @(posedge clk); #2; check("rerel_v3", 32'(rvalid4), 1);
        check("rerel_rbin", 32'(rbin4), 32'(4'b1111));
      end
    join_none
    step4(1, 1, 0, 4'h0, 4'h2, 4'b0011, 0);
    step4(1, 1, 0, 4'h0, 4'h3, 4'b0010, 0);
    idle4();

    // Randomised WIDTH=8 run; u_dut8 has sat at 0 since the last reset.
    m = 8'h00;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      en8   = ($urandom_range(0, 3) != 0);
      up8   = 1'($urandom_range(0, 1));
      load8 = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 4))
        0:       lb8 = 8'h00;
        1:       lb8 = 8'h01;
        2:       lb8 = 8'hFE;
        3:       lb8 = 8'hFF;
        default: lb8 = 8'($urandom_range(0, 255));
      endcase
      w = 1'b0;
      if (load8) m = lb8;
      else if (en8) begin
        if (up8) begin w = (m == 8'hFF); m = m + 8'd1; end
        else     begin w = (m == 8'h00); m = m - 8'd1; end
      end
      exp8_q.push_back({w, m});
    end
    @(negedge clk); en8 = 1'b0; load8 = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("drain4", 32'(exp4_q.size()), 0);
    check("drain8", 32'(exp8_q.size()), 0);
    check("rbin8",   32'(rbin8),   0);
    check("rvalid8", 32'(rvalid8), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
